ctx_reg_bank: RTL and testbench
===============================

Name: ctx_reg_bank

Overview:
- Parametrised successor to the single-purpose PC/IR/address registers of the multicycle CPU.
- Holds CHANNELS independent WIDTH-bit architectural registers (e.g. ch0 = PC, ch1 = IR, ch2 = address register), each with its own write enable.
- Adds a DEPTH-entry LIFO shadow stack that snapshots or restores all channels at once, for exception entry/return and nested exceptions.
- Sits between the control FSM and the datapath, replacing the discrete register instances.

Parameters:
- WIDTH, 32, bits per channel.
- CHANNELS, 3, number of registers in the bank.
- DEPTH, 4, number of shadow-stack snapshot entries (≥1).
- RESET_VAL, 0, reset value loaded into every channel.

Ports:
- Clk  input  1  clock; all state updates on the falling edge.
- Rst  input  1  reset, synchronous, active-high.
- wr_en  input  CHANNELS  per-channel write enable; bit k controls channel k.
- d_in  input  CHANNELS*WIDTH  write data; channel k occupies bits [k*WIDTH +: WIDTH].
- q_out  output  CHANNELS*WIDTH  current register contents, same packing as d_in.
- save  input  1  push snapshot of all channels onto the shadow stack.
- restore  input  1  pop top snapshot into all channels.
- err_clr  input  1  clear both sticky error flags.
- depth_cnt  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  depth_cnt == DEPTH.
- stack_empty  output  1  depth_cnt == 0.
- ovf_err  output  1  sticky: save attempted while full.
- unf_err  output  1  sticky: restore attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock, Clk; all registers update on negedge Clk.
  - Reset is synchronous, active-high, sampled at the same falling edge.
  - On Rst: every channel = RESET_VAL, depth_cnt = 0, ovf_err = unf_err = 0.
  - Stack storage is not reset; its contents are don't-care.
  - Rst overrides all other inputs, including mid-sequence (e.g. depth 3 with save asserted).
- Timing:
  - q_out, flags and depth_cnt are registered outputs.
  - A new value is visible immediately after the updating edge; zero additional latency.
  - stack_full and stack_empty are decoded from registered depth_cnt; they are not separately stored.
- Normal write: for each k with wr_en[k]=1, channel k ← d_in slice k. Channels with wr_en[k]=0 hold.
- Save (save=1, restore=0):
  - Not full: stack[depth_cnt] ← pre-edge q_out (all channels); depth_cnt + 1.
  - Writes requested on the same edge also apply, so the stack holds old values and the registers hold new ones.
  - Full: no push, depth_cnt unchanged, ovf_err ← 1; writes still apply.
- Restore (restore=1, save=0):
  - Not empty: all channels ← stack[depth_cnt-1]; depth_cnt - 1; wr_en is ignored for that edge.
  - Empty: no pop, unf_err ← 1; writes apply normally.
- save and restore both 1: no stack operation, no error, depth_cnt unchanged; writes apply normally.
- Stack order is LIFO; no wrap-around.
- Error flags:
  - Both are sticky until err_clr or Rst.
  - If err_clr and a new error occur on the same edge, the flag is set (set wins).
- Priority, highest first: Rst > restore (valid) > save/writes.

Test Plan:
- Reset: hold Rst one edge with save=1, wr_en=3'b111 → q_out all 0, depth_cnt=0, stack_empty=1, stack_full=0, ovf_err=unf_err=0.
- Per-channel write: wr_en=3'b010, ch1 data 0xDEADBEEF, others 0xFFFFFFFF → only ch1=0xDEADBEEF; ch0 and ch2 remain 0.
- Save with simultaneous write: ch0=0x00000010; save=1 and wr_en=3'b001 with ch0 data 0x80000180 → ch0=0x80000180, depth_cnt=1. Next edge restore=1 with wr_en=3'b001 and data 0x5 → ch0=0x00000010 (write ignored), depth_cnt=0.
- Overflow and LIFO order:
  - Write ch0=1..4, saving after each write → after 4 saves depth_cnt=4, stack_full=1.
  - 5th save → ovf_err=1, depth_cnt stays 4.
  - 4 restores → ch0 returns 4,3,2,1.
  - 5th restore → unf_err=1, ch0 stays 1.
- save and restore both asserted at depth 2 with wr_en=3'b100 and ch2 data 0xABCD → depth_cnt stays 2, ch2=0xABCD, no error flags set.
- Reset mid-operation and err_clr:
  - At depth 3 with ovf_err=1, assert Rst → depth_cnt=0, q_out=0, ovf_err=0.
  - Then at empty, assert restore with err_clr on the same edge → unf_err=1 (set wins).
  - Next edge err_clr alone → unf_err=0.

Source files
------------

// File: rtl/ctx_reg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctx_reg_bank_if
//  Purpose  : Bus bundle between the control FSM (master) and the context
//             register bank (slave): write port, stack controls and status.
//  Revision : 1.0  initial release
// ============================================================================
interface ctx_reg_bank_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 3,
   parameter int DEPTH    = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CHANNELS-1:0]       wr_en;
   logic [CHANNELS*WIDTH-1:0] d_in;
   logic [CHANNELS*WIDTH-1:0] q_out;
   logic                      save;
   logic                      restore;
   logic                      err_clr;
   logic [CW-1:0]             depth_cnt;
   logic                      stack_full;
   logic                      stack_empty;
   logic                      ovf_err;
   logic                      unf_err;

   modport master (
      output wr_en, d_in, save, restore, err_clr,
      input  q_out, depth_cnt, stack_full, stack_empty, ovf_err, unf_err
   );

   modport slave (
      input  wr_en, d_in, save, restore, err_clr,
      output q_out, depth_cnt, stack_full, stack_empty, ovf_err, unf_err
   );
endinterface
`default_nettype wire

// File: rtl/ctx_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ctx_reg_bank
//  Purpose  : CHANNELS independent WIDTH-bit architectural registers with
//             per-channel write enables and a DEPTH-entry LIFO shadow stack
//             that snapshots/restores every channel at once.
//             All state updates on the falling edge of Clk.
//  Revision : 1.0  initial release
// ============================================================================
module ctx_reg_bank #(
   parameter int               WIDTH     = 32,
   parameter int               CHANNELS  = 3,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic          Clk,
   input  logic          Rst,
   ctx_reg_bank_if.slave bus
);
   localparam int            CW          = $clog2(DEPTH + 1);
   // Stack index width; a single-entry stack still needs one address bit.
   localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] C_DEPTH_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE       = CW'(1);

   logic [CHANNELS*WIDTH-1:0] regs_q, regs_d;
   logic [CHANNELS*WIDTH-1:0] stack_q [DEPTH];
   logic [CW-1:0]             depth_q, depth_d;
   logic                      ovf_q, ovf_d;
   logic                      unf_q, unf_d;

   logic                      w_full, w_empty;
   logic                      w_save_op, w_restore_op;
   logic                      w_push, w_pop;
   logic [AW-1:0]             w_push_idx, w_pop_idx;

   assign w_full       = (depth_q == C_DEPTH_MAX);
   assign w_empty      = (depth_q == '0);
   // save and restore together cancel out: no stack operation, no error.
   assign w_save_op    = bus.save & ~bus.restore;
   assign w_restore_op = bus.restore & ~bus.save;
   assign w_push       = w_save_op & ~w_full;
   assign w_pop        = w_restore_op & ~w_empty;
   // Push index is only used while not full, so depth_q < DEPTH fits AW bits.
   assign w_push_idx   = AW'(depth_q);
   assign w_pop_idx    = AW'(depth_q - C_ONE);

   // Next-state: a valid pop overrides writes; otherwise per-channel writes apply.
   always_comb begin
      regs_d  = regs_q;
      depth_d = depth_q;
      ovf_d   = ovf_q & ~bus.err_clr;
      unf_d   = unf_q & ~bus.err_clr;
      if (w_pop) begin
         regs_d  = stack_q[w_pop_idx];
         depth_d = depth_q - C_ONE;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (bus.wr_en[k]) begin
               regs_d[k*WIDTH +: WIDTH] = bus.d_in[k*WIDTH +: WIDTH];
            end
         end
         if (w_push) begin
            depth_d = depth_q + C_ONE;
         end
      end
      // A fresh error beats a simultaneous clear.
      if (w_save_op && w_full) begin
         ovf_d = 1'b1;
      end
      if (w_restore_op && w_empty) begin
         unf_d = 1'b1;
      end
   end

   // Architectural registers, depth counter and sticky flags.
   always_ff @(negedge Clk) begin
      if (Rst) begin
         regs_q  <= {CHANNELS{RESET_VAL}};
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Shadow stack storage captures pre-edge register contents; never reset.
   always_ff @(negedge Clk) begin
      if (!Rst && w_push) begin
         stack_q[w_push_idx] <= regs_q;
      end
   end

   assign bus.q_out       = regs_q;
   assign bus.depth_cnt   = depth_q;
   assign bus.stack_full  = w_full;
   assign bus.stack_empty = w_empty;
   assign bus.ovf_err     = ovf_q;
   assign bus.unf_err     = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_ctx_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctx_reg_bank
//  Purpose  : Directed plus random stimulus for ctx_reg_bank, compared each
//             falling edge against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctx_reg_bank;
   localparam int W  = 32;
   localparam int C  = 3;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   logic Clk = 1'b1;
   logic Rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   ctx_reg_bank_if #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) bus ();

   ctx_reg_bank #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .RESET_VAL('0)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   // Reference model: channel array plus a LIFO queue of whole snapshots.
   logic [W-1:0]   m_reg [C];
   logic [C*W-1:0] m_stk [$];
   logic           m_ovf, m_unf;

   function automatic logic [C*W-1:0] pk(logic [W-1:0] c0, logic [W-1:0] c1, logic [W-1:0] c2);
      return {c2, c1, c0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic rst, input logic [C-1:0] wr, input logic [C*W-1:0] din,
                        input logic sv, input logic rs, input logic clr);
      logic [C*W-1:0] snap;
      logic           writes_ok;
      if (rst) begin
         for (int k = 0; k < C; k++) m_reg[k] = '0;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         for (int k = 0; k < C; k++) snap[k*W +: W] = m_reg[k];
         if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         writes_ok = 1'b1;
         if (sv && !rs) begin
            if (m_stk.size() < D) m_stk.push_back(snap);
            else m_ovf = 1'b1;
         end else if (rs && !sv) begin
            if (m_stk.size() > 0) begin
               snap = m_stk.pop_back();
               for (int k = 0; k < C; k++) m_reg[k] = snap[k*W +: W];
               writes_ok = 1'b0;
            end else begin
               m_unf = 1'b1;
            end
         end
         if (writes_ok) begin
            for (int k = 0; k < C; k++) if (wr[k]) m_reg[k] = din[k*W +: W];
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < C; k++) begin
         chk($sformatf("q_ch%0d", k), 64'(bus.q_out[k*W +: W]), 64'(m_reg[k]));
      end
      chk("depth_cnt", 64'(bus.depth_cnt), 64'(m_stk.size()));
      chk("stack_full", 64'(bus.stack_full), 64'(m_stk.size() == D));
      chk("stack_empty", 64'(bus.stack_empty), 64'(m_stk.size() == 0));
      chk("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
      chk("unf_err", 64'(bus.unf_err), 64'(m_unf));
   endtask

   // Drive one set of inputs, let the falling edge take them, then compare.
   task automatic step(input logic rst, input logic [C-1:0] wr, input logic [C*W-1:0] din,
                       input logic sv, input logic rs, input logic clr);
      Rst         = rst;
      bus.wr_en   = wr;
      bus.d_in    = din;
      bus.save    = sv;
      bus.restore = rs;
      bus.err_clr = clr;
      @(negedge Clk);
      #1;
      model(rst, wr, din, sv, rs, clr);
      check_all();
   endtask

   initial begin
      for (int k = 0; k < C; k++) m_reg[k] = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      bus.wr_en = '0; bus.d_in = '0; bus.save = 1'b0; bus.restore = 1'b0; bus.err_clr = 1'b0;

      // Reset overrides save and writes.
      step(1, 3'b111, {C*W{1'b1}}, 1, 0, 0);
      chk("rst_q", 64'(bus.q_out), 64'd0);
      chk("rst_empty", 64'(bus.stack_empty), 64'd1);

      // Single-channel write.
      step(0, 3'b010, pk(32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF), 0, 0, 0);
      chk("wr_ch1", 64'(bus.q_out[W +: W]), 64'hDEAD_BEEF);
      chk("wr_ch0", 64'(bus.q_out[0 +: W]), 64'd0);

      // Save with simultaneous write, then restore ignoring the write.
      step(0, 3'b001, pk(32'h10, 0, 0), 0, 0, 0);
      step(0, 3'b001, pk(32'h8000_0180, 0, 0), 1, 0, 0);
      chk("sv_wr_ch0", 64'(bus.q_out[0 +: W]), 64'h8000_0180);
      chk("sv_depth", 64'(bus.depth_cnt), 64'd1);
      step(0, 3'b001, pk(32'h5, 0, 0), 0, 1, 0);
      chk("rs_ch0", 64'(bus.q_out[0 +: W]), 64'h10);

      // Fill, overflow, LIFO drain, underflow.
      for (int i = 1; i <= 4; i++) begin
         step(0, 3'b001, pk(32'(i), 0, 0), 0, 0, 0);
         step(0, 3'b000, '0, 1, 0, 0);
      end
      chk("fill_full", 64'(bus.stack_full), 64'd1);
      step(0, 3'b000, '0, 1, 0, 0);
      chk("ovf_set", 64'(bus.ovf_err), 64'd1);
      chk("ovf_depth", 64'(bus.depth_cnt), 64'd4);
      for (int i = 4; i >= 1; i--) begin
         step(0, 3'b000, '0, 0, 1, 0);
         chk("lifo_ch0", 64'(bus.q_out[0 +: W]), 64'(i));
      end
      step(0, 3'b000, '0, 0, 1, 0);
      chk("unf_set", 64'(bus.unf_err), 64'd1);
      chk("unf_ch0", 64'(bus.q_out[0 +: W]), 64'd1);

      // save+restore together at depth 2: no stack op, write applies.
      step(0, 3'b000, '0, 0, 0, 1);
      step(0, 3'b000, '0, 1, 0, 0);
      step(0, 3'b000, '0, 1, 0, 0);
      step(0, 3'b100, pk(0, 0, 32'hABCD), 1, 1, 0);
      chk("both_depth", 64'(bus.depth_cnt), 64'd2);
      chk("both_ch2", 64'(bus.q_out[2*W +: W]), 64'hABCD);
      chk("both_flags", 64'({bus.ovf_err, bus.unf_err}), 64'd0);

      // Reach depth 3 with ovf_err set, then reset mid-sequence.
      step(0, 3'b000, '0, 1, 0, 0);
      step(0, 3'b000, '0, 1, 0, 0);
      step(0, 3'b000, '0, 1, 0, 0);
      step(0, 3'b000, '0, 0, 1, 0);
      chk("pre_rst_depth", 64'(bus.depth_cnt), 64'd3);
      chk("pre_rst_ovf", 64'(bus.ovf_err), 64'd1);
      step(1, 3'b111, {C*W{1'b1}}, 1, 0, 0);
      chk("mid_rst_depth", 64'(bus.depth_cnt), 64'd0);
      chk("mid_rst_ovf", 64'(bus.ovf_err), 64'd0);

      // Set beats clear, then clear alone.
      step(0, 3'b000, '0, 0, 1, 1);
      chk("set_wins", 64'(bus.unf_err), 64'd1);
      step(0, 3'b000, '0, 0, 0, 1);
      chk("clr_unf", 64'(bus.unf_err), 64'd0);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0),
              3'($urandom),
              {$urandom, $urandom, $urandom},
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
